// File: rtl/axis_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axis_mem_pkg
//  Description : Shared types and constants for the heap memory -> AXI-Stream
//                read path: reader FSM state encoding, word/address stepping
//                and the full tkeep pattern.
//  Revision    : 1.0 - initial release
// ============================================================================
package axis_mem_pkg;

  // Reader FSM states, explicitly 2 bits wide.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } rd_state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int ADDR_STEP      = 4;

  // All byte lanes of a 32-bit beat are valid.
  localparam logic [3:0] KEEP_FULL = 4'hF;

endpackage
`default_nettype wire

// File: rtl/axis_skid_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : axis_skid_fifo
//  Description : Small synchronous FIFO holding {last, data} payloads between
//                the BRAM read pipeline and the AXI-Stream output. Depth need
//                not be a power of two; pointers wrap explicitly.
//  Ports       : clk          - clock
//                rst_n        - asynchronous active-low reset (empties FIFO)
//                i_push       - write strobe (ignored when full)
//                i_push_data  - payload to write
//                i_pop        - read strobe (ignored when empty)
//                o_pop_data   - payload at the head
//                o_count      - current occupancy
//                o_empty      - occupancy == 0
//                o_full       - occupancy == DEPTH
//  Revision    : 1.0 - initial release
// ============================================================================
module axis_skid_fifo #(
  parameter  int WIDTH = 33,
  parameter  int DEPTH = 3,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_pop_data,
  output logic [CNT_W-1:0] o_count,
  output logic             o_empty,
  output logic             o_full
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty    = (r_count == '0);
  assign o_full     = (r_count == CNT_W'(DEPTH));
  assign o_count    = r_count;
  assign o_pop_data = r_mem[r_rd_ptr];

  assign w_do_push  = i_push && !o_full;
  assign w_do_pop   = i_pop && !o_empty;

  // Storage carries no reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/memory_to_axis.sv
`default_nettype none
// ============================================================================
//  Module      : memory_to_axis
//  Description : Streams a contiguous block of 32-bit heap words, read from
//                BRAM port B, out as a single AXI-Stream packet. Reads are
//                issued under a credit limit so every returning word has a
//                FIFO slot, making the path immune to downstream backpressure.
//  Options     : MEMORY_TO_AXIS_STALL_CNT_EN - adds stall_cycles[31:0], a
//                saturating count of tvalid && !tready cycles in the current
//                transfer (cleared on start, held after done).
//  Ports       : axis_clk / axis_aresetn       - clock, async active-low reset
//                start, rd_start_addr,
//                rd_len_words                  - single-cycle command
//                busy, done                    - transfer status
//                heap_mem_port_b_*             - BRAM read port
//                m_axis_*                      - AXI-Stream master
//  Revision    : 1.0 - initial release
// ============================================================================
module memory_to_axis
  import axis_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 11,
  parameter int LEN_WIDTH  = 16,
  parameter int RD_LATENCY = 1
) (
  input  logic                  axis_clk,
  input  logic                  axis_aresetn,
  input  logic                  start,
  input  logic [31:0]           rd_start_addr,
  input  logic [LEN_WIDTH-1:0]  rd_len_words,
  output logic                  busy,
  output logic                  done,
  output logic                  heap_mem_port_b_clk,
  output logic [ADDR_WIDTH-1:0] heap_mem_port_b_addr,
  output logic                  heap_mem_port_b_en,
  input  logic [31:0]           heap_mem_port_b_rd_data,
  output logic [31:0]           m_axis_tdata,
  output logic [3:0]            m_axis_tkeep,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready
`ifdef MEMORY_TO_AXIS_STALL_CNT_EN
  ,
  output logic [31:0]           stall_cycles
`endif
);

  localparam int FIFO_DEPTH = RD_LATENCY + 2;
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
  localparam int SUM_W      = CNT_W + 1;

  rd_state_t             r_state;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_en;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] r_next_addr;
  logic [LEN_WIDTH-1:0]  r_len;
  logic [LEN_WIDTH-1:0]  r_issue_idx;

  // Read tags: stage 0 is the read issued this cycle (mirrors en); stage
  // RD_LATENCY lines up with valid rd_data.
  logic [RD_LATENCY:0]   r_tag_vld;
  logic [RD_LATENCY:0]   r_tag_last;

  logic [CNT_W-1:0]      w_in_flight;
  logic [CNT_W-1:0]      w_fifo_count;
  logic                  w_fifo_empty;
  logic                  w_fifo_full;
  logic [32:0]           w_head;
  logic                  w_tvalid;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_credit_ok;
  logic                  w_issue;
  logic                  w_issue_last;
  logic                  w_unused;

  assign heap_mem_port_b_clk  = axis_clk;
  assign heap_mem_port_b_addr = r_addr;
  assign heap_mem_port_b_en   = r_en;
  assign busy                 = r_busy;
  assign done                 = r_done;

  assign w_tvalid      = !w_fifo_empty;
  assign w_pop         = w_tvalid && m_axis_tready;
  assign w_push        = r_tag_vld[RD_LATENCY];

  assign m_axis_tvalid = w_tvalid;
  assign m_axis_tdata  = w_tvalid ? w_head[31:0] : 32'h0;
  assign m_axis_tlast  = w_tvalid && w_head[32];
  assign m_axis_tkeep  = w_tvalid ? KEEP_FULL : 4'h0;

  always_comb begin
    w_in_flight = '0;
    for (int i = 0; i <= RD_LATENCY; i++) begin
      w_in_flight = w_in_flight + CNT_W'(r_tag_vld[i]);
    end
  end

  // A read issued now must still find a slot after this edge's push/pop, so
  // the slot freed by a same-cycle pop is credited immediately; this keeps
  // one beat per cycle sustainable with tready high.
  assign w_credit_ok  = ({1'b0, w_in_flight} + {1'b0, w_fifo_count} - SUM_W'(w_pop))
                        < SUM_W'(FIFO_DEPTH);
  assign w_issue      = (r_state == ISSUE) && w_credit_ok;
  assign w_issue_last = (r_issue_idx == (r_len - LEN_WIDTH'(1)));

  assign w_unused     = ^{rd_start_addr[31:ADDR_WIDTH], w_fifo_full};

  always_ff @(posedge axis_clk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      r_tag_vld  <= '0;
      r_tag_last <= '0;
    end else begin
      r_tag_vld  <= {r_tag_vld[RD_LATENCY-1:0], w_issue};
      r_tag_last <= {r_tag_last[RD_LATENCY-1:0], w_issue && w_issue_last};
    end
  end

  always_ff @(posedge axis_clk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      r_state     <= IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_en        <= 1'b0;
      r_addr      <= '0;
      r_next_addr <= '0;
      r_len       <= '0;
      r_issue_idx <= '0;
    end else begin
      r_done <= 1'b0;
      r_en   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            if (rd_len_words != '0) begin
              r_next_addr <= rd_start_addr[ADDR_WIDTH-1:0];
              r_len       <= rd_len_words;
              r_issue_idx <= '0;
              r_busy      <= 1'b1;
              r_state     <= ISSUE;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (w_issue) begin
            r_en        <= 1'b1;
            r_addr      <= r_next_addr;
            // Natural overflow of the address register gives the wrap.
            r_next_addr <= r_next_addr + ADDR_WIDTH'(ADDR_STEP);
            r_issue_idx <= r_issue_idx + LEN_WIDTH'(1);
            if (w_issue_last) begin
              r_state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (w_pop && w_head[32]) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  axis_skid_fifo #(
    .WIDTH (33),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (axis_clk),
    .rst_n       (axis_aresetn),
    .i_push      (w_push),
    .i_push_data ({r_tag_last[RD_LATENCY], heap_mem_port_b_rd_data}),
    .i_pop       (w_pop),
    .o_pop_data  (w_head),
    .o_count     (w_fifo_count),
    .o_empty     (w_fifo_empty),
    .o_full      (w_fifo_full)
  );

`ifdef MEMORY_TO_AXIS_STALL_CNT_EN
  logic [31:0] r_stall_cycles;

  always_ff @(posedge axis_clk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      r_stall_cycles <= '0;
    end else if ((r_state == IDLE) && start) begin
      r_stall_cycles <= '0;
    end else if (r_busy && w_tvalid && !m_axis_tready && (r_stall_cycles != '1)) begin
      r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign stall_cycles = r_stall_cycles;
`endif

endmodule
`default_nettype wire
